spi_dac_responder: RTL
======================

SPI_DAC_RESPONDER -- requirements
Module: spi_dac_responder

Interface
REQ-001 Parameter WORD_BITS, default 24: frame length in bits, MSB first.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for Sck, Mosi and nCs.
REQ-003 Port clk, input, 1: sole clock; Sck must be at most clk/4.
REQ-004 Port nRst, input, 1: reset; reset is asynchronous and active-low.
REQ-005 Port Sck, input, 1: SPI clock from the DM SPI master; mode 0 (idle low, sample on rising edge).
REQ-006 Port Mosi, input, 1: serial data from the master.
REQ-007 Port nCs, input, 1: active-low frame select.
REQ-008 Port Miso, output, 1: serial readback to the master.
REQ-009 Port TxData, input, WORD_BITS: word returned on Miso, captured at frame start.
REQ-010 Port RxData, output, WORD_BITS: last complete received word.
REQ-011 Port RxValid, output, 1: one-clk pulse marking a new RxData.
REQ-012 Port FrameError, output, 1: one-clk pulse marking a short or long frame.
REQ-013 Port FrameCount, output, 16: count of good frames.

Function
REQ-014 Sck, Mosi and nCs SHALL each pass through SYNC_STAGES flops, then one extra flop for edge detection; all logic below uses the synchronized copies.
REQ-015 FSM states SHALL be ARMED, IDLE, SHIFT and CHECK.
REQ-016 ARMED is entered from reset; ARMED SHALL go to IDLE only after synchronized nCs has been sampled high.
REQ-017 IDLE SHALL go to SHIFT on a synchronized nCs falling edge.
REQ-018 On that IDLE-to-SHIFT transition: load the tx shift register from TxData, clear the bit counter, set Miso to TxData[WORD_BITS-1].
REQ-019 In SHIFT, each synchronized Sck rising edge SHALL shift Mosi into the LSB of the rx shift register.
REQ-020 Each such rising edge SHALL increment the bit counter, saturating at WORD_BITS+1.
REQ-021 In SHIFT, each synchronized Sck falling edge SHALL shift the tx register left by one, fill with 0, and drive its new MSB on Miso.
REQ-022 In SHIFT, a synchronized nCs rising edge SHALL move the FSM to CHECK.
REQ-023 If the nCs rising edge and an Sck edge are detected in the same clk, nCs SHALL take precedence and the Sck edge SHALL be ignored.
REQ-024 CHECK is one cycle; if bit count equals WORD_BITS: RxData updates to the rx register, RxValid pulses on the next clk edge, FrameCount increments.
REQ-025 In CHECK, if bit count differs from WORD_BITS (short, including zero, or long): RxData is unchanged, FrameError pulses, FrameCount is unchanged.
REQ-026 CHECK SHALL always return to IDLE.
REQ-027 Latency: RxValid SHALL assert exactly 2 clk after the cycle in which the synchronized nCs rising edge is detected.
REQ-028 Bits beyond WORD_BITS SHALL not enter RxData.
REQ-029 FrameCount SHALL wrap from 0xFFFF to 0x0000.
REQ-030 Miso SHALL be 0 in ARMED, IDLE and CHECK.
REQ-031 TxData changes during SHIFT SHALL have no effect until the next frame.
REQ-032 RxValid and FrameError SHALL never be high in the same cycle.

Reset
REQ-033 On nRst low, asynchronously: FSM to ARMED, all synchronizers to the idle level (Sck 0, nCs 1, Mosi 0), Miso 0, RxData 0, RxValid 0, FrameError 0, FrameCount 0, shift registers and bit counter 0.
REQ-034 A frame in progress when nRst asserts SHALL be discarded with no RxValid and no FrameError.
REQ-035 If nCs is already low when nRst deasserts, the remainder of that frame SHALL be ignored (held in ARMED).

Verification
REQ-036 24-bit frame Mosi=0xA5C3F0, TxData=0x123456 -> RxData=0xA5C3F0, Miso bit stream 0x123456, RxValid one pulse 2 clk after synchronized nCs rise, FrameCount=1.
REQ-037 23-clock frame, then 25-clock frame -> FrameError pulses twice, RxData holds prior value, FrameCount unchanged.
REQ-038 nCs rise coincident with the 24th synchronized Sck rising edge -> edge dropped, FrameError, no RxValid.
REQ-039 nRst pulsed at bit 12 with nCs held low through the frame end -> no RxValid or FrameError; the next full frame is received correctly with FrameCount=1.
REQ-040 Preload FrameCount to 0xFFFF via 65535 frames (or force), then one good frame -> FrameCount=0x0000, RxValid asserted.
REQ-041 Back-to-back frames with a 4-clk nCs-high gap, TxData changed mid-frame -> each frame returns the TxData value sampled at its own nCs fall.

Source files
------------

// File: rtl/spi_dac_responder.sv
// SPI mode-0 responder: receives a WORD_BITS frame on Mosi, returns TxData on Miso, and validates frame length.
// Latency: RxValid/FrameError pulse 2 clk after the synchronized nCs rise is detected. There is no backpressure.
// Sck must run at clk/4 or slower. Every frame is accepted or flagged.
module spi_dac_responder #(
    parameter int WORD_BITS   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 Sck,
    input  logic                 Mosi,
    input  logic                 nCs,
    output logic                 Miso,
    input  logic [WORD_BITS-1:0] TxData,
    output logic [WORD_BITS-1:0] RxData,
    output logic                 RxValid,
    output logic                 FrameError,
    output logic [15:0]          FrameCount
);

    localparam int CNT_W = $clog2(WORD_BITS + 2);
    localparam int ARM_W = $clog2(SYNC_STAGES + 2) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_BITS + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {ARMED, IDLE, SHIFT, CHECK} state_t;

    state_t state, stateNext;

    logic [SYNC_STAGES-1:0] sckSync, mosiSync, csSync;
    logic                   sckDly, csDly;
    logic                   sckS, mosiS, csS;
    logic                   sckRise, sckFall, csRise, csFall;

    logic [WORD_BITS-1:0]   rxShift, txShift;
    logic [CNT_W-1:0]       bitCnt;
    logic [ARM_W-1:0]       armCnt;
    logic                   armDone;

    logic loadTx, rxShiftEn, txShiftEn, commit, flagError;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sckSync  <= '0;
            mosiSync <= '0;
            csSync   <= '1;
            sckDly   <= 1'b0;
            csDly    <= 1'b1;
        end else begin
            sckSync[0]  <= Sck;
            mosiSync[0] <= Mosi;
            csSync[0]   <= nCs;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sckSync[i]  <= sckSync[i-1];
                mosiSync[i] <= mosiSync[i-1];
                csSync[i]   <= csSync[i-1];
            end
            sckDly <= sckSync[SYNC_STAGES-1];
            csDly  <= csSync[SYNC_STAGES-1];
        end
    end

    assign sckS    = sckSync[SYNC_STAGES-1];
    assign mosiS   = mosiSync[SYNC_STAGES-1];
    assign csS     = csSync[SYNC_STAGES-1];
    assign sckRise = sckS & ~sckDly;
    assign sckFall = ~sckS & sckDly;
    assign csRise  = csS & ~csDly;
    assign csFall  = ~csS & csDly;

    // The synchronizers reset to idle levels, so ARMED waits for them to flush before trusting nCs.
    assign armDone = (armCnt == ARM_DONE);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            armCnt <= '0;
        end else if (state == ARMED && !armDone) begin
            armCnt <= armCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= ARMED;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        loadTx    = 1'b0;
        rxShiftEn = 1'b0;
        txShiftEn = 1'b0;
        commit    = 1'b0;
        flagError = 1'b0;
        case (state)
            ARMED: begin
                if (armDone && csS) begin
                    stateNext = IDLE;
                end
            end
            IDLE: begin
                if (csFall) begin
                    stateNext = SHIFT;
                    loadTx    = 1'b1;
                end
            end
            SHIFT: begin
                // An nCs rise swallows any Sck edge seen in the same cycle.
                if (csRise) begin
                    stateNext = CHECK;
                end else begin
                    rxShiftEn = sckRise;
                    txShiftEn = sckFall;
                end
            end
            CHECK: begin
                stateNext = IDLE;
                if (bitCnt == CNT_FULL) begin
                    commit = 1'b1;
                end else begin
                    flagError = 1'b1;
                end
            end
            default: stateNext = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rxShift    <= '0;
            txShift    <= '0;
            bitCnt     <= '0;
            Miso       <= 1'b0;
            RxData     <= '0;
            RxValid    <= 1'b0;
            FrameError <= 1'b0;
            FrameCount <= '0;
        end else begin
            RxValid    <= commit;
            FrameError <= flagError;
            if (commit) begin
                RxData     <= rxShift;
                FrameCount <= FrameCount + 16'd1;
            end

            if (loadTx) begin
                rxShift <= '0;
                txShift <= TxData;
                bitCnt  <= '0;
            end else begin
                if (rxShiftEn) begin
                    if (bitCnt < CNT_FULL) begin
                        rxShift <= {rxShift[WORD_BITS-2:0], mosiS};
                    end
                    if (bitCnt != CNT_MAX) begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                if (txShiftEn) begin
                    txShift <= {txShift[WORD_BITS-2:0], 1'b0};
                end
            end

            if (loadTx) begin
                Miso <= TxData[WORD_BITS-1];
            end else if (txShiftEn) begin
                Miso <= txShift[WORD_BITS-2];
            end else if (stateNext != SHIFT) begin
                Miso <= 1'b0;
            end
        end
    end

endmodule
